sm3_pad_arb: RTL and testbench
==============================

Name: sm3_pad_arb

Overview:
- Round-robin message-level arbiter that lets CH_NUM independent padded-message sources share the single SM3 expansion core input (pad_inpt_* bus).
- Once a channel is granted, it keeps the grant for its whole message, i.e. until its last beat is accepted.
- Records the channel ID of every granted message in an in-order ID queue, so the downstream digest result can be routed back to its source.
- Sits between the channel-side padding units and the expansion core input.

Parameters:
- CH_NUM, 2, number of requesting channels (2..8).
- DW, 64, padded data beat width (32 or 64, matching the expansion core build).
- IDQ_DEPTH, 4, outstanding-message ID queue depth (power of 2, >=2).
- CW, derived: max(1, $clog2(CH_NUM)), channel ID width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_d_i  in  CH_NUM*DW  per-channel padded data; channel k occupies bits [k*DW +: DW].
- req_vld_i  in  CH_NUM  per-channel beat valid.
- req_lst_i  in  CH_NUM  per-channel last beat of message.
- req_rdy_o  out  CH_NUM  per-channel beat accept.
- pad_inpt_d_o  out  DW  data to expansion core.
- pad_inpt_vld_o  out  1  valid to expansion core.
- pad_inpt_lst_o  out  1  last to expansion core.
- pad_inpt_rdy_i  in  1  expansion core ready.
- res_vld_i  in  1  one-cycle pulse, digest of oldest in-flight message complete.
- res_id_o  out  CW  channel ID owning the oldest in-flight message (queue head).
- res_id_vld_o  out  1  queue non-empty.
- busy_o  out  1  state==LOCK or queue non-empty.
- err_o  out  1  sticky: res_vld_i seen while queue empty.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, rr_ptr=0, ID queue empty.
  - All outputs 0: req_rdy_o, pad_inpt_*_o, res_id_o, res_id_vld_o, busy_o, err_o.
  - Reset mid-message drops the message; the source must restart it.
- FSM IDLE:
  - Condition: any req_vld_i[k]=1 and queue not full.
  - Select the first asserted channel searching upward from rr_ptr, wrapping modulo CH_NUM.
  - Registered on the next edge: gnt<=k, rr_ptr<=(k+1)%CH_NUM, ID k pushed to queue, state<=LOCK.
  - While queue is full, IDLE holds and no grant is issued.
  - In IDLE: all req_rdy_o=0 and pad_inpt_vld_o=0.
- FSM LOCK:
  - Combinational mux from channel gnt:
    - pad_inpt_d_o = req_d_i[gnt]
    - pad_inpt_vld_o = req_vld_i[gnt]
    - pad_inpt_lst_o = req_lst_i[gnt]
    - req_rdy_o[gnt] = pad_inpt_rdy_i
  - All other req_rdy_o bits are 0.
  - A beat transfers when vld && rdy.
  - On a transfer with lst=1: state<=IDLE.
  - Exactly one idle cycle separates consecutive messages (grant bubble).
  - Valid may drop mid-message; the grant is held regardless.
- ID queue: FIFO, IDQ_DEPTH entries of CW bits, with separate wrap-around read/write pointers and a count.
  - Push: at grant.
  - Pop: res_vld_i && !empty.
  - Simultaneous push and pop: count unchanged; both pointers advance.
  - Full: count==IDQ_DEPTH; blocks new grants but does not affect a message already in LOCK.
- Result routing:
  - res_id_o = queue head (registered FIFO storage; combinational read of head).
  - res_id_vld_o = !empty.
  - The consumer samples res_id_o in the same cycle as res_vld_i.
- Error: res_vld_i=1 while empty sets err_o=1 until reset; no pop, pointers unchanged.
- Latency: request-valid to first accepted beat is 1 cycle minimum (grant register).
- No data-path registers; the datapath is combinational in LOCK.
- Simultaneous requests are resolved purely by rr_ptr; no channel can starve, worst case (CH_NUM-1) messages.

Test Plan:
- Single-message grant: ch0 sends a 3-beat message (lst on beat 3), rdy=1.
  - -> req_rdy_o[0]=1 from cycle 1 after vld.
  - -> pad_inpt_lst_o on beat 3.
  - -> queue count=1, res_id_o=0; res_vld_i pulse -> res_id_vld_o=0.
- Round-robin fairness: CH_NUM=2, ch0 and ch1 both continuously request 2-beat messages.
  - -> grants alternate 0,1,0,1, with exactly 1 idle cycle between messages.
  - -> queue holds IDs 0,1 in order.
- Backpressure with lock hold: ch1 granted, pad_inpt_rdy_i toggles 1,0,1 while ch0 requests.
  - -> ch1 keeps the grant until its lst beat transfers.
  - -> req_rdy_o[0] stays 0 throughout.
- Queue full: IDQ_DEPTH=4, four messages granted with no res_vld_i.
  - -> fifth request is not granted and busy_o=1.
  - -> one res_vld_i pulse -> grant issued on the next cycle.
- Simultaneous push and pop: res_vld_i pulses in the same cycle as a new grant.
  - -> count unchanged; head advances to the next ID.
- Reset mid-message plus error: assert rst during beat 2 of a message.
  - -> all outputs 0 immediately.
  - After release, res_vld_i pulse -> err_o=1 and remains 1.

Source files
------------

// File: rtl/sm3_pad_arb.sv
// Round-robin arbiter that merges padded-message channels onto the single SM3 expansion input.
// A grant lasts for a whole message. Granted channel IDs queue in order so digests can be routed back.
module sm3_pad_arb #(
  parameter int  CH_NUM    = 2,
  parameter int  DW        = 64,
  parameter int  IDQ_DEPTH = 4,
  localparam int CW        = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_NUM*DW-1:0] req_d_i,
  input  logic [CH_NUM-1:0]    req_vld_i,
  input  logic [CH_NUM-1:0]    req_lst_i,
  output logic [CH_NUM-1:0]    req_rdy_o,
  output logic [DW-1:0]        pad_inpt_d_o,
  output logic                 pad_inpt_vld_o,
  output logic                 pad_inpt_lst_o,
  input  logic                 pad_inpt_rdy_i,
  input  logic                 res_vld_i,
  output logic [CW-1:0]        res_id_o,
  output logic                 res_id_vld_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int AW = $clog2(IDQ_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     gnt_q, rr_q, rr_next;
  logic [CW-1:0]     pick_id;
  logic [CW:0]       pick_off, pick_sum;
  logic              pick_vld;
  logic [2*CH_NUM-1:0] vld_dbl;
  logic [CH_NUM-1:0] vld_rot;

  logic [CW-1:0]     idq_mem [IDQ_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [NW-1:0]     idq_cnt;
  logic              idq_empty, idq_full, push, pop, err_q;

  assign idq_empty = (idq_cnt == '0);
  assign idq_full  = (idq_cnt == NW'(IDQ_DEPTH));
  assign push      = (state_q == IDLE) && pick_vld && !idq_full;
  assign pop       = res_vld_i && !idq_empty;

  // Rotate the request vector so bit 0 is the channel at rr_q; first set bit wins.
  assign vld_dbl = {req_vld_i, req_vld_i};
  assign vld_rot = CH_NUM'(vld_dbl >> rr_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!pick_vld && vld_rot[i]) begin
        pick_vld = 1'b1;
        pick_off = (CW+1)'(i);
      end
    end
    pick_sum = {1'b0, rr_q} + pick_off;
    pick_id  = (pick_sum >= (CW+1)'(CH_NUM)) ? CW'(pick_sum - (CW+1)'(CH_NUM)) : CW'(pick_sum);
  end

  assign rr_next = (pick_id == CW'(CH_NUM - 1)) ? '0 : pick_id + CW'(1);

  always_comb begin
    state_d        = state_q;
    req_rdy_o      = '0;
    pad_inpt_d_o   = '0;
    pad_inpt_vld_o = 1'b0;
    pad_inpt_lst_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) state_d = LOCK;
      end
      LOCK: begin
        for (int k = 0; k < CH_NUM; k++) begin
          if (gnt_q == CW'(k)) begin
            pad_inpt_d_o   = req_d_i[k*DW +: DW];
            pad_inpt_vld_o = req_vld_i[k];
            pad_inpt_lst_o = req_lst_i[k];
            req_rdy_o[k]   = pad_inpt_rdy_i;
          end
        end
        if (pad_inpt_vld_o && pad_inpt_rdy_i && pad_inpt_lst_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        gnt_q <= pick_id;
        rr_q  <= rr_next;
      end
    end
  end

  // In-order ID queue; the pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      idq_cnt <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < IDQ_DEPTH; i++) idq_mem[i] <= '0;
    end else begin
      if (push) begin
        idq_mem[wr_ptr] <= pick_id;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   idq_cnt <= idq_cnt + NW'(1);
        2'b01:   idq_cnt <= idq_cnt - NW'(1);
        default: idq_cnt <= idq_cnt;
      endcase
      if (res_vld_i && idq_empty) err_q <= 1'b1;
    end
  end

  assign res_id_o     = idq_mem[rd_ptr];
  assign res_id_vld_o = !idq_empty;
  assign busy_o       = (state_q == LOCK) || !idq_empty;
  assign err_o        = err_q;

endmodule

// File: tb/tb_sm3_pad_arb.sv
// Bench for sm3_pad_arb: vector table, directed corner sequences, then random traffic
// checked every cycle against a queue-based model of the arbitration rules.
module tb_sm3_pad_arb;
  localparam int CH_NUM = 2;
  localparam int DW = 64;
  localparam int IDQ_DEPTH = 4;
  localparam int CW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH_NUM*DW-1:0] req_d = '0;
  logic [CH_NUM-1:0] req_vld = '0, req_lst = '0, req_rdy_o;
  logic [DW-1:0] pad_inpt_d_o;
  logic pad_inpt_vld_o, pad_inpt_lst_o, rdy_in = 1'b0, res_vld = 1'b0;
  logic [CW-1:0] res_id_o;
  logic res_id_vld_o, busy_o, err_o;

  int tests = 0, fails = 0, cyc = 0;

  // Model state: owning channel (-1 when no grant), round-robin start, ID queue, sticky error.
  int owner = -1, rr = 0;
  int q[$];
  bit err_m = 0;

  always #5 clk = ~clk;

  sm3_pad_arb #(.CH_NUM(CH_NUM), .DW(DW), .IDQ_DEPTH(IDQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_d_i(req_d), .req_vld_i(req_vld), .req_lst_i(req_lst),
    .req_rdy_o(req_rdy_o), .pad_inpt_d_o(pad_inpt_d_o), .pad_inpt_vld_o(pad_inpt_vld_o),
    .pad_inpt_lst_o(pad_inpt_lst_o), .pad_inpt_rdy_i(rdy_in), .res_vld_i(res_vld),
    .res_id_o(res_id_o), .res_id_vld_o(res_id_vld_o), .busy_o(busy_o), .err_o(err_o));

  typedef struct {
    logic [1:0] vld, lst;
    logic       rdy, rv;
    logic [7:0] exp;  // {req_rdy[1:0], vld, lst, id_vld, id, busy, err}
  } vec_t;
  vec_t vecs[6];

  function automatic void model_reset();
    owner = -1; rr = 0; q.delete(); err_m = 0;
  endfunction

  function automatic void model_step();
    int  pre = q.size();
    bit  do_grant = 0;
    int  k = 0;
    if (owner < 0) begin
      if (req_vld != 0 && pre < IDQ_DEPTH)
        for (int i = 0; i < CH_NUM; i++) begin
          int c = (rr + i) % CH_NUM;
          if (!do_grant && req_vld[c]) begin do_grant = 1; k = c; end
        end
    end else if (req_vld[owner] && rdy_in && req_lst[owner]) begin
      owner = -1;
    end
    if (res_vld) begin
      if (q.size() == 0) err_m = 1;
      else void'(q.pop_front());
    end
    if (do_grant) begin q.push_back(k); owner = k; rr = (k + 1) % CH_NUM; end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [CH_NUM-1:0] e_rdy;
    logic e_vld, e_lst, e_idv, e_busy;
    logic [DW-1:0] e_d;
    int e_id;
    bit ok;
    e_rdy = '0; e_vld = 0; e_lst = 0; e_d = '0;
    if (owner >= 0) begin
      e_vld = req_vld[owner]; e_lst = req_lst[owner];
      e_d = req_d[owner*DW +: DW]; e_rdy[owner] = rdy_in;
    end
    e_idv  = (q.size() != 0);
    e_busy = (owner >= 0) || e_idv;
    e_id   = e_idv ? q[0] : 0;
    ok = (req_rdy_o === e_rdy) && (pad_inpt_vld_o === e_vld) && (pad_inpt_lst_o === e_lst) &&
         (pad_inpt_d_o === e_d) && (res_id_vld_o === e_idv) && (busy_o === e_busy) && (err_o === err_m);
    if (e_idv && (res_id_o !== CW'(e_id))) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL model cyc=%0d rdy %b/%b vld %b/%b lst %b/%b d %h/%h idv %b/%b id %0d/%0d busy %b/%b err %b/%b",
               cyc, req_rdy_o, e_rdy, pad_inpt_vld_o, e_vld, pad_inpt_lst_o, e_lst, pad_inpt_d_o, e_d,
               res_id_vld_o, e_idv, res_id_o, e_id, busy_o, e_busy, err_o, err_m);
    end
  endtask

  task automatic settle();
    #1; check_model();
  endtask

  task automatic tick();
    @(posedge clk); model_step(); cyc++; #1;
  endtask

  initial begin
    int bc[2];
    int starts[$];
    int first_start, last_end;
    logic [1:0] prev_rdy;
    logic [3:0] seq;
    bit hold_ok, bp_ok, err_ok;

    vecs[0] = '{2'b01, 2'b00, 1'b1, 1'b0, 8'b00_0_0_0_0_0_0};
    vecs[1] = '{2'b01, 2'b00, 1'b1, 1'b0, 8'b01_1_0_1_0_1_0};
    vecs[2] = '{2'b01, 2'b00, 1'b1, 1'b0, 8'b01_1_0_1_0_1_0};
    vecs[3] = '{2'b01, 2'b01, 1'b1, 1'b0, 8'b01_1_1_1_0_1_0};
    vecs[4] = '{2'b00, 2'b00, 1'b1, 1'b1, 8'b00_0_0_1_0_1_0};
    vecs[5] = '{2'b00, 2'b00, 1'b1, 1'b0, 8'b00_0_0_0_0_0_0};

    // Reset with requests pending: every output must stay low.
    req_vld = 2'b11; rdy_in = 1'b1; req_d = {64'hBBBB_0000_1111_2222, 64'hAAAA_3333_4444_5555};
    #2;
    chk("reset_ctl", {req_rdy_o, pad_inpt_vld_o, pad_inpt_lst_o, res_id_o, res_id_vld_o, busy_o, err_o}, 0);
    chk("reset_data", pad_inpt_d_o, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0; model_reset();

    foreach (vecs[i]) begin
      req_vld = vecs[i].vld; req_lst = vecs[i].lst; rdy_in = vecs[i].rdy; res_vld = vecs[i].rv;
      settle();
      chk($sformatf("vec%0d", i),
          {req_rdy_o, pad_inpt_vld_o, pad_inpt_lst_o, res_id_vld_o, res_id_o, busy_o, err_o}, vecs[i].exp);
      tick();
    end

    // Round robin: both channels stream 2-beat messages until the ID queue fills.
    bc[0] = 0; bc[1] = 0; prev_rdy = '0; first_start = -1; last_end = -1;
    for (int c = 0; c < 20; c++) begin
      req_vld = 2'b11; rdy_in = 1'b1; res_vld = 1'b0;
      req_lst = {bc[1] == 1, bc[0] == 1};
      settle();
      if (req_rdy_o != 0 && prev_rdy == 0) begin
        starts.push_back(req_rdy_o[1] ? 1 : 0);
        if (first_start < 0) first_start = c;
      end
      for (int k = 0; k < 2; k++)
        if (req_rdy_o[k] && req_vld[k]) begin
          if (req_lst[k]) begin bc[k] = 0; last_end = c; end
          else bc[k]++;
        end
      prev_rdy = req_rdy_o;
      tick();
    end
    seq = '0;
    foreach (starts[i]) if (i < 4) seq[i] = starts[i][0];
    chk("rr_msg_count", starts.size(), 4);
    chk("rr_order", seq, 4'b0101);
    chk("rr_span", last_end - first_start, 10);

    // Queue full: requests pending but no grant until a result pops an entry.
    hold_ok = 1;
    req_lst = 2'b00;
    for (int c = 0; c < 3; c++) begin
      settle();
      if (!(req_rdy_o == 0 && busy_o && res_id_vld_o)) hold_ok = 0;
      tick();
    end
    chk("full_hold", hold_ok, 1);
    res_vld = 1'b1; settle(); chk("full_head", res_id_o, 1); tick();
    res_vld = 1'b0; settle();
    chk("full_pop_edge_no_grant", req_rdy_o, 2'b00);
    chk("full_head_next", res_id_o, 0);
    tick();
    req_vld = 2'b10; req_lst = 2'b10; settle(); chk("full_regrant", req_rdy_o, 2'b10); tick();

    // Drain two, then grant and pop in the same cycle.
    req_vld = 2'b00; req_lst = 2'b00; res_vld = 1'b1;
    settle(); tick(); settle(); tick();
    req_vld = 2'b01; settle(); chk("pp_head_before", res_id_o, 0); tick();
    res_vld = 1'b0; req_lst = 2'b01; settle();
    chk("pp_after", {req_rdy_o, res_id_vld_o, res_id_o}, {2'b01, 1'b1, 1'b1});
    tick();
    req_vld = 2'b00; req_lst = 2'b00; res_vld = 1'b1;
    settle(); chk("pp_drain1", res_id_o, 1); tick();
    settle(); chk("pp_drain2", {res_id_vld_o, res_id_o}, 2'b10); tick();
    res_vld = 1'b0; settle(); chk("pp_empty", res_id_vld_o, 0); tick();

    // Backpressure: ch1 holds the lock through a stalled last beat while ch0 waits.
    bp_ok = 1;
    req_vld = 2'b11; req_lst = 2'b00; rdy_in = 1'b1; settle(); tick();
    settle(); if (req_rdy_o != 2'b10) bp_ok = 0; tick();
    rdy_in = 1'b0; req_lst = 2'b10; settle();
    if (!(req_rdy_o == 2'b00 && pad_inpt_vld_o && pad_inpt_lst_o)) bp_ok = 0;
    tick();
    rdy_in = 1'b1; settle(); if (!(req_rdy_o == 2'b10 && pad_inpt_lst_o)) bp_ok = 0; tick();
    req_lst = 2'b00; settle(); if (req_rdy_o != 2'b00) bp_ok = 0; tick();
    chk("bp_lock_hold", bp_ok, 1);

    for (int c = 0; c < 3000; c++) begin
      req_vld = 2'($urandom_range(0, 3));
      req_lst = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      rdy_in  = ($urandom_range(0, 3) != 0);
      res_vld = ($urandom_range(0, 4) == 0);
      req_d   = {$urandom, $urandom, $urandom, $urandom};
      settle(); tick();
    end

    // Reset in the middle of a message, then a result with nothing outstanding.
    req_vld = 2'b00; res_vld = 1'b0; rst = 1'b1; #1;
    @(posedge clk); #1; rst = 1'b0; model_reset();
    req_vld = 2'b01; req_lst = 2'b00; rdy_in = 1'b1;
    settle(); tick(); settle(); tick();
    settle(); chk("mid_lock", req_rdy_o, 2'b01);
    rst = 1'b1; #1;
    chk("midrst_ctl", {req_rdy_o, pad_inpt_vld_o, pad_inpt_lst_o, res_id_o, res_id_vld_o, busy_o, err_o}, 0);
    chk("midrst_data", pad_inpt_d_o, 0);
    @(posedge clk); #1; rst = 1'b0; model_reset();
    req_vld = 2'b00; res_vld = 1'b1; settle(); tick();
    res_vld = 1'b0; err_ok = 1;
    for (int c = 0; c < 3; c++) begin
      settle(); if (err_o !== 1'b1) err_ok = 0; tick();
    end
    chk("err_sticky", err_ok, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
